// File: rtl/product_display.sv
`default_nettype none
// ============================================================================
// Module   : product_display
// Brief    : Captures the multiplier product on a rising ready edge, converts
//            it to BCD with a sequential double-dabble engine and scans it onto
//            a 3-digit common-anode seven-segment display.
//            Optional leading-zero blanking: define PRODUCT_DISPLAY_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module product_display #(
    parameter int REFRESH_DIV = 3330
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ready,
    input  logic [7:0] product,
    output logic       busy,
    output logic [6:0] seg,
    output logic [2:0] dig
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_conv = 2'd1;
    localparam logic [1:0] c_st_load = 2'd2;
    localparam int         c_cnt_w   = $clog2(REFRESH_DIV);

    logic [1:0]         r_state;
    logic               r_ready_q;
    logic               r_rst_hold;
    logic [19:0]        r_shift;
    logic [2:0]         r_iter;
    logic               r_busy;
    logic [3:0]         r_hund;
    logic [3:0]         r_tens;
    logic [3:0]         r_units;
    logic [c_cnt_w-1:0] r_refresh;
    logic [1:0]         r_digit;
    logic [6:0]         r_seg;
    logic [2:0]         r_dig;

    logic        w_capture;
    logic [19:0] w_adj;
    logic [3:0]  w_hund_n;
    logic [3:0]  w_tens_n;
    logic [3:0]  w_units_n;
    logic        w_wrap;
    logic [1:0]  w_digit_n;
    logic [3:0]  w_val;
    logic        w_blank;
    logic [6:0]  w_seg_n;
    logic [2:0]  w_dig_n;

    // r_rst_hold masks the first post-reset cycle so a ready held across reset is not an edge
    assign w_capture = ready & ~r_ready_q & ~r_rst_hold & (r_state == c_st_idle);

    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 3; i++) begin
            if (r_shift[8+4*i +: 4] >= 4'd5) begin
                w_adj[8+4*i +: 4] = r_shift[8+4*i +: 4] + 4'd3;
            end
        end
    end

    // Feed the freshly converted digits straight into the segment register during LOAD
    assign w_hund_n  = (r_state == c_st_load) ? r_shift[19:16] : r_hund;
    assign w_tens_n  = (r_state == c_st_load) ? r_shift[15:12] : r_tens;
    assign w_units_n = (r_state == c_st_load) ? r_shift[11:8]  : r_units;

    assign w_wrap    = (r_refresh == c_cnt_w'(REFRESH_DIV - 1));
    assign w_digit_n = !w_wrap ? r_digit : ((r_digit >= 2'd2) ? 2'd0 : r_digit + 2'd1);

    always_comb begin
        case (w_digit_n)
            2'd1:    w_val = w_tens_n;
            2'd2:    w_val = w_hund_n;
            default: w_val = w_units_n;
        endcase
    end

`ifdef PRODUCT_DISPLAY_BLANK_EN
    assign w_blank = ((w_digit_n == 2'd2) && (w_hund_n == 4'd0)) ||
                     ((w_digit_n == 2'd1) && (w_hund_n == 4'd0) && (w_tens_n == 4'd0));
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        case (w_val)
            4'd0:    w_seg_n = 7'b1000000;
            4'd1:    w_seg_n = 7'b1111001;
            4'd2:    w_seg_n = 7'b0100100;
            4'd3:    w_seg_n = 7'b0110000;
            4'd4:    w_seg_n = 7'b0011001;
            4'd5:    w_seg_n = 7'b0010010;
            4'd6:    w_seg_n = 7'b0000010;
            4'd7:    w_seg_n = 7'b1111000;
            4'd8:    w_seg_n = 7'b0000000;
            4'd9:    w_seg_n = 7'b0010000;
            default: w_seg_n = 7'h7F;
        endcase
        if (w_blank) begin
            w_seg_n = 7'h7F;
        end
    end

    assign w_dig_n = ~(3'b001 << w_digit_n);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_ready_q  <= 1'b0;
            r_rst_hold <= 1'b1;
            r_shift    <= 20'd0;
            r_iter     <= 3'd0;
            r_busy     <= 1'b0;
            r_hund     <= 4'd0;
            r_tens     <= 4'd0;
            r_units    <= 4'd0;
            r_refresh  <= '0;
            r_digit    <= 2'd0;
            r_seg      <= 7'b1000000;
            r_dig      <= 3'b110;
        end else begin
            r_ready_q  <= ready;
            r_rst_hold <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_capture) begin
                        r_shift <= {12'd0, product};
                        r_iter  <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_conv;
                    end
                end
                c_st_conv: begin
                    r_shift <= w_adj << 1;
                    r_iter  <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_hund  <= w_hund_n;
                    r_tens  <= w_tens_n;
                    r_units <= w_units_n;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
            r_refresh <= w_wrap ? '0 : r_refresh + c_cnt_w'(1);
            r_digit   <= w_digit_n;
            r_seg     <= w_seg_n;
            r_dig     <= w_dig_n;
        end
    end

    assign busy = r_busy;
    assign seg  = r_seg;
    assign dig  = r_dig;

endmodule
`default_nettype wire

// File: tb/tb_product_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_product_display
// Brief    : Directed bench for product_display with REFRESH_DIV = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_product_display;

    localparam int         c_div  = 4;
    localparam logic [6:0] c_s0   = 7'b1000000;
    localparam logic [6:0] c_s2   = 7'b0100100;
    localparam logic [6:0] c_s3   = 7'b0110000;
    localparam logic [6:0] c_s5   = 7'b0010010;
    localparam logic [6:0] c_s7   = 7'b1111000;
    localparam logic [6:0] c_s9   = 7'b0010000;
`ifdef PRODUCT_DISPLAY_BLANK_EN
    localparam logic [6:0] c_lz   = 7'h7F;
`else
    localparam logic [6:0] c_lz   = c_s0;
`endif
    localparam logic [2:0] c_units = 3'b110;
    localparam logic [2:0] c_tens  = 3'b101;
    localparam logic [2:0] c_hund  = 3'b011;

    logic       clock;
    logic       reset;
    logic       ready;
    logic [7:0] product;
    logic       busy;
    logic [6:0] seg;
    logic [2:0] dig;

    int n_vec  = 0;
    int n_miss = 0;

    product_display #(.REFRESH_DIV(c_div)) dut (
        .clock   (clock),
        .reset   (reset),
        .ready   (ready),
        .product (product),
        .busy    (busy),
        .seg     (seg),
        .dig     (dig)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Wait (bounded) until the requested digit is lit, then compare its segments
    task automatic show(input string tag, input logic [2:0] pat, input logic [6:0] exp_seg);
        int n = 0;
        while (dig !== pat && n < 3 * c_div + 2) begin
            tick(1);
            n++;
        end
        check({tag, "_dig"}, 32'(dig), 32'(pat));
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    // Count busy-high samples from now on, bounded
    task automatic busy_len(output int len);
        len = 0;
        while (busy === 1'b1 && len < 20) begin
            len++;
            tick(1);
        end
    endtask

    task automatic convert(input string tag, input logic [7:0] p);
        int len;
        product = p;
        ready   = 1'b1;
        tick(1);
        busy_len(len);
        check({tag, "_busy_len"}, 32'(len), 32'd9);
        ready = 1'b0;
        tick(1);
    endtask

    initial begin
        int len;
        reset   = 1'b1;
        ready   = 1'b0;
        product = 8'd0;
        tick(3);
        reset = 1'b0;
        check("rst_dig", 32'(dig), 32'(c_units));
        check("rst_seg", 32'(seg), 32'(c_s0));
        check("rst_busy", 32'(busy), 32'd0);
        tick(4);
        check("scan_tens", 32'(dig), 32'(c_tens));
        tick(4);
        check("scan_hund", 32'(dig), 32'(c_hund));
        tick(4);
        check("scan_wrap", 32'(dig), 32'(c_units));

        convert("p35", 8'd35);
        show("p35_u", c_units, c_s5);
        show("p35_t", c_tens, c_s3);
        show("p35_h", c_hund, c_lz);

        convert("p255", 8'd255);
        show("p255_u", c_units, c_s5);
        show("p255_t", c_tens, c_s5);
        show("p255_h", c_hund, c_s2);

        convert("p0", 8'd0);
        show("p0_u", c_units, c_s0);
        show("p0_t", c_tens, c_lz);
        show("p0_h", c_hund, c_lz);

        convert("p99", 8'd99);
        show("p99_u", c_units, c_s9);
        show("p99_t", c_tens, c_s9);

        // Re-trigger during conversion must be ignored
        product = 8'd35;
        ready   = 1'b1;
        tick(1);
        tick(2);
        ready = 1'b0;
        tick(1);
        ready   = 1'b1;
        product = 8'd99;
        busy_len(len);
        check("ign_busy_rest", 32'(len), 32'd6);
        tick(3);
        check("ign_no_recapture", 32'(busy), 32'd0);
        show("ign_u", c_units, c_s5);
        show("ign_t", c_tens, c_s3);
        show("ign_h", c_hund, c_lz);
        ready = 1'b0;
        tick(2);

        // Reset on E4 of a conversion, ready held high across release
        product = 8'd7;
        ready   = 1'b1;
        tick(1);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_dig", 32'(dig), 32'(c_units));
        check("mid_rst_seg", 32'(seg), 32'(c_s0));
        reset = 1'b0;
        tick(3);
        check("hold_no_capture", 32'(busy), 32'd0);
        show("hold_t", c_tens, c_lz);
        ready = 1'b0;
        tick(1);

        convert("p7", 8'd7);
        show("p7_u", c_units, c_s7);
        show("p7_t", c_tens, c_lz);
        show("p7_h", c_hund, c_lz);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
